// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Only add/sub, slt, or and and are implemented by the ALU.
  function automatic logic funct3_supported(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b010, 3'b110, 3'b111: funct3_supported = 1'b1;
      default:                        funct3_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_aludec.sv
// ALU decoder: maps ALUOp plus instruction fields to an ALU operation code.
module multicycle_ctrl_aludec
  import multicycle_ctrl_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic [1:0] alu_op,
  output logic [2:0] alu_control
);

  // funct3/funct7 decode; SUB only for R-type (op5=1) with bit 30 set
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core, with memory wait
// counter, immediate-format decode and sticky illegal/timeout flags.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       illegal,
  output logic       timeout,
  output logic [3:0] state_o
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          illegal_q, illegal_d;
  logic          timeout_q, timeout_d;
  logic          expired_s, wait_state_s;
  logic          pc_write_s, ir_write_s, mem_write_s, reg_write_s;
  logic [1:0]    alu_op_s;

  // State, wait counter and sticky flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      wait_cnt_q <= CNT_ZERO;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state logic; mem_ready takes priority over an expiring wait
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    expired_s = (wait_cnt_q == CNT_LAST) && !mem_ready;
    case (state_q)
      FETCH: begin
        if (mem_ready) begin
          state_d = DECODE;
        end else if (expired_s) begin
          state_d   = TRAP;
          timeout_d = 1'b1;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = funct3_supported(funct3) ? EXECR : TRAP;
          OP_I:         state_d = funct3_supported(funct3) ? EXECI : TRAP;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = TRAP;
        endcase
        if (state_d == TRAP) begin
          illegal_d = 1'b1;
        end else begin
          illegal_d = illegal_q;
        end
      end
      MEMADR: state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD, MEMWRITE: begin
        if (mem_ready) begin
          state_d = (state_q == MEMREAD) ? MEMWB : FETCH;
        end else if (expired_s) begin
          state_d   = TRAP;
          timeout_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      MEMWB:        state_d = FETCH;
      EXECR, EXECI: state_d = ALUWB;
      ALUWB:        state_d = FETCH;
      BEQ:          state_d = FETCH;
      JAL:          state_d = ALUWB;
      TRAP:         state_d = TRAP;
      default:      state_d = TRAP;
    endcase

    wait_state_s = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
    if (state_d != state_q) begin
      wait_cnt_d = CNT_ZERO;
    end else if (wait_state_s && !mem_ready) begin
      wait_cnt_d = wait_cnt_q + CNT_ONE;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Moore outputs; JAL's write-back ALUWB is where it completes
  always_comb begin
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_op_s    = ALUOP_ADD;
    instr_done  = 1'b0;
    case (state_q)
      FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      MEMREAD: adr_src = 1'b1;
      MEMWB: begin
        result_src  = RES_DATA;
        reg_write_s = 1'b1;
        instr_done  = 1'b1;
      end
      MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
        instr_done  = mem_ready;
      end
      EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op_s  = ALUOP_FUNCT;
      end
      EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op_s  = ALUOP_FUNCT;
      end
      ALUWB: begin
        reg_write_s = 1'b1;
        instr_done  = 1'b1;
      end
      BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_op_s   = ALUOP_SUB;
        pc_write_s = zero;
        instr_done = 1'b1;
      end
      JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write_s = 1'b1;
      end
      TRAP:    instr_done = 1'b0;
      default: instr_done = 1'b0;
    endcase
  end

  // Immediate format follows the opcode directly
  always_comb begin
    case (op)
      OP_LW, OP_I: imm_src = IMM_I;
      OP_SW:       imm_src = IMM_S;
      OP_BEQ:      imm_src = IMM_B;
      OP_JAL:      imm_src = IMM_J;
      default:     imm_src = IMM_I;
    endcase
  end

  assign pc_write  = pc_write_s  & ~reset;
  assign ir_write  = ir_write_s  & ~reset;
  assign mem_write = mem_write_s & ~reset;
  assign reg_write = reg_write_s & ~reset;
  assign illegal   = illegal_q;
  assign timeout   = timeout_q;
  assign state_o   = state_q;

  multicycle_ctrl_aludec u_aludec (
    .op5        (op[5]),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .alu_op     (alu_op_s),
    .alu_control(alu_control)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class, the
// memory wait/timeout boundary, illegal opcodes and asynchronous reset.
module tb_multicycle_ctrl;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                         S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5,
                         S_EXECR = 4'd6, S_EXECI = 4'd7, S_ALUWB = 4'd8,
                         S_BEQ = 4'd9, S_JAL = 4'd10, S_TRAP = 4'd11;

  logic       clk, reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5, zero, mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       instr_done, illegal, timeout;
  logic [3:0] state_o;

  int errors = 0;
  int checks = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .imm_src(imm_src), .alu_control(alu_control), .instr_done(instr_done),
    .illegal(illegal), .timeout(timeout), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; op = 7'b0; funct3 = 3'b0; funct7_5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b1;
    #3;
    chk("rst_state", 32'(state_o), 32'(S_FETCH));
    chk("rst_pc_write", 32'(pc_write), 32'd0);
    chk("rst_ir_write", 32'(ir_write), 32'd0);
    chk("rst_flags", 32'({illegal, timeout}), 32'd0);
    tick();
    reset = 1'b0;

    // lw, 5 cycles
    op = 7'b0000011;
    #1;
    chk("fetch_pc_write", 32'(pc_write), 32'd1);
    chk("fetch_ir_write", 32'(ir_write), 32'd1);
    chk("fetch_srcb", 32'(alu_src_b), 32'd2);
    chk("fetch_result_src", 32'(result_src), 32'd2);
    tick(); chk("lw_decode", 32'(state_o), 32'(S_DECODE));
    chk("decode_srcs", 32'({alu_src_a, alu_src_b}), 32'b0101);
    tick(); chk("lw_memadr", 32'(state_o), 32'(S_MEMADR));
    chk("memadr_srcs", 32'({alu_src_a, alu_src_b, adr_src}), 32'b10010);
    tick(); chk("lw_memread", 32'(state_o), 32'(S_MEMREAD));
    chk("memread_adr", 32'({adr_src, instr_done}), 32'b10);
    tick(); chk("lw_memwb", 32'(state_o), 32'(S_MEMWB));
    chk("memwb_outs", 32'({reg_write, result_src, instr_done}), 32'b1011);
    tick(); chk("lw_done", 32'(state_o), 32'(S_FETCH));

    // R-type sub
    op = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1;
    tick(); tick();
    chk("sub_execr", 32'(state_o), 32'(S_EXECR));
    chk("sub_alu", 32'(alu_control), 32'b001);
    chk("execr_srcs", 32'({alu_src_a, alu_src_b}), 32'b1000);
    tick(); chk("sub_aluwb", 32'(state_o), 32'(S_ALUWB));
    chk("aluwb_outs", 32'({reg_write, result_src, instr_done}), 32'b1001);
    tick(); chk("sub_done", 32'(state_o), 32'(S_FETCH));

    // addi with bit 30 set is still ADD
    op = 7'b0010011;
    tick(); tick();
    chk("addi_execi", 32'(state_o), 32'(S_EXECI));
    chk("addi_alu", 32'(alu_control), 32'b000);
    chk("execi_srcb", 32'(alu_src_b), 32'b01);
    tick(); tick();

    // or (R, funct3=110)
    op = 7'b0110011; funct3 = 3'b110; funct7_5 = 1'b0;
    tick(); tick();
    chk("or_alu", 32'(alu_control), 32'b011);
    tick(); tick();

    // slti (funct3=010)
    op = 7'b0010011; funct3 = 3'b010;
    tick(); tick();
    chk("slti_alu", 32'(alu_control), 32'b101);
    tick(); tick();

    // beq taken, then not taken; 3 cycles each
    op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    #1; chk("beq_imm", 32'(imm_src), 32'b10);
    tick(); tick();
    chk("beq_state", 32'(state_o), 32'(S_BEQ));
    chk("beq_taken_pcw", 32'(pc_write), 32'd1);
    chk("beq_alu", 32'(alu_control), 32'b001);
    chk("beq_done", 32'(instr_done), 32'd1);
    tick(); chk("beq_back", 32'(state_o), 32'(S_FETCH));
    zero = 1'b0;
    tick(); tick();
    chk("beq_nt_pcw", 32'(pc_write), 32'd0);
    tick(); chk("beq_nt_back", 32'(state_o), 32'(S_FETCH));

    // jal: completes in ALUWB only
    op = 7'b1101111;
    #1; chk("jal_imm", 32'(imm_src), 32'b11);
    tick(); tick();
    chk("jal_state", 32'(state_o), 32'(S_JAL));
    chk("jal_outs", 32'({pc_write, alu_src_a, alu_src_b, instr_done}), 32'b101100);
    tick(); chk("jal_aluwb", 32'(state_o), 32'(S_ALUWB));
    chk("jal_wb_done", 32'({reg_write, instr_done}), 32'b11);
    tick(); chk("jal_back", 32'(state_o), 32'(S_FETCH));

    // sw with 3 wait cycles: mem_write high 4 cycles
    op = 7'b0100011;
    #1; chk("sw_imm", 32'(imm_src), 32'b01);
    tick(); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sw_wait_state", 32'(state_o), 32'(S_MEMWRITE));
      chk("sw_wait_mw", 32'({mem_write, adr_src, instr_done}), 32'b110);
    end
    tick();
    mem_ready = 1'b1;
    #1;
    chk("sw_ready_mw", 32'({mem_write, instr_done}), 32'b11);
    tick(); chk("sw_back", 32'(state_o), 32'(S_FETCH));
    chk("sw_back_mw", 32'(mem_write), 32'd0);

    // mem_ready arriving on the last allowed cycle avoids the trap
    tick(); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    chk("edge_state", 32'(state_o), 32'(S_MEMWRITE));
    mem_ready = 1'b1;
    tick();
    chk("edge_no_trap", 32'(state_o), 32'(S_FETCH));
    chk("edge_timeout", 32'(timeout), 32'd0);

    // 16 cycles without mem_ready -> TRAP
    tick(); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("to_wait_mw", 32'(mem_write), 32'd1);
    end
    tick();
    chk("to_trap", 32'(state_o), 32'(S_TRAP));
    chk("to_flag", 32'({timeout, illegal}), 32'b10);
    mem_ready = 1'b1;
    #1;
    chk("to_enables", 32'({pc_write, ir_write, mem_write, reg_write}), 32'd0);
    tick(); chk("to_hold", 32'(state_o), 32'(S_TRAP));

    // async reset clears timeout, then reset mid-MEMWRITE
    #1; reset = 1'b1; #1;
    chk("rst1_state", 32'(state_o), 32'(S_FETCH));
    chk("rst1_timeout", 32'(timeout), 32'd0);
    tick(); reset = 1'b0;
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    chk("mid_mw", 32'(mem_write), 32'd1);
    #1; reset = 1'b1; #1;
    chk("mid_rst_mw", 32'(mem_write), 32'd0);
    chk("mid_rst_state", 32'(state_o), 32'(S_FETCH));
    chk("mid_rst_flags", 32'({illegal, timeout}), 32'd0);
    tick(); reset = 1'b0; mem_ready = 1'b1;

    // illegal opcode traps and stays sticky
    op = 7'b1110011;
    tick(); tick();
    chk("ill_trap", 32'(state_o), 32'(S_TRAP));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("ill_sticky", 32'({illegal, state_o}), 32'({1'b1, S_TRAP}));
    end
    #1; reset = 1'b1; #1;
    chk("ill_cleared", 32'(illegal), 32'd0);
    tick(); reset = 1'b0;

    // unsupported funct3 on R-type
    op = 7'b0110011; funct3 = 3'b001;
    tick(); tick();
    chk("f3_trap", 32'({illegal, state_o}), 32'({1'b1, S_TRAP}));

    // FETCH holds while memory is not ready
    #1; reset = 1'b1; #1;
    tick(); reset = 1'b0; mem_ready = 1'b0;
    #1;
    chk("fetch_wait_en", 32'({pc_write, ir_write}), 32'd0);
    tick();
    chk("fetch_hold", 32'(state_o), 32'(S_FETCH));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
